icache_refill_axi: RTL and testbench

- AXI read-only master that turns an instruction-cache miss into one INCR burst read of a full cache line.
- Sits directly upstream of the 2-to-1 AXI crossbar and drives crossbar slave slot 1, the burst-capable read slot.
- Streams each returned beat to the cache data RAM with its word index, then pulses a completion strobe.

---
 rtl/axi_cfg_pkg.sv | 14 +
 rtl/icache_refill_axi_if.sv | 25 ++
 rtl/icache_refill_axi_beat_ctr.sv | 23 ++
 rtl/icache_refill_axi.sv | 120 ++++++++++++
 tb/tb_icache_refill_axi.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_cfg_pkg.sv
// Shared AXI constants and the refill FSM state type for the icache refill master.
package axi_cfg_pkg;

  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;
  localparam logic [3:0] ICACHE_AXI_ID = 4'd1;

  typedef enum logic [1:0] {IDLE, AR, R, DONE} refill_state_t;

  // Byte-offset mask of one cache line of 32-bit words.
  function automatic logic [63:0] line_off_mask(input int line_words);
    return 64'(line_words * 4 - 1);
  endfunction

endpackage

// File: rtl/icache_refill_axi_if.sv
// AXI read-address / read-data channel bundle between the refill master and crossbar slot 1.
interface icache_refill_axi_if #(
  parameter int ADDR_W = 32
);
  logic [3:0]        m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [3:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rlast, m_rvalid
  );

  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rlast, m_rvalid
  );
endinterface

// File: rtl/icache_refill_axi_beat_ctr.sv
// Beat counter for one line refill: synchronous clear, count enable, terminal-count flag.
module refill_beat_ctr #(
  parameter int LINE_WORDS = 16,
  localparam int IDX_W = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + IDX_W'(1);
  end

  assign tc = (cnt == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/icache_refill_axi.sv
// Icache miss -> single line-aligned INCR burst read; beats streamed to the data RAM.
// Optional REFILL_RLAST_CHECK_EN flags m_rlast that disagrees with the beat count.
module icache_refill_axi
  import axi_cfg_pkg::*;
#(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [ADDR_W-1:0]             miss_addr,
  icache_refill_axi_if.master           m,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [31:0]                   fill_data,
  output logic                          fill_done,
  output logic                          fill_err
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(line_off_mask(LINE_WORDS));

  refill_state_t     state_q, state_d;
  logic [ADDR_W-1:0] araddr_q;
  logic              ctr_clr, beat;
  logic [IDX_W-1:0]  ctr;
  logic              ctr_tc;

  refill_beat_ctr #(.LINE_WORDS(LINE_WORDS)) u_ctr (
    .clk (aclk),
    .rst (areset),
    .clr (ctr_clr),
    .en  (beat),
    .cnt (ctr),
    .tc  (ctr_tc)
  );

  assign m.m_arid   = ICACHE_AXI_ID;
  assign m.m_arlen  = 4'(LINE_WORDS - 1);
  assign m.m_arsize = AXI_SIZE_WORD;
  assign m.m_araddr = araddr_q;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    miss_ready  = 1'b0;
    m.m_arvalid = 1'b0;
    m.m_rready  = 1'b0;
    fill_done   = 1'b0;
    ctr_clr     = 1'b0;
    beat        = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_d = AR;
      end
      AR: begin
        m.m_arvalid = 1'b1;
        if (m.m_arready) begin
          ctr_clr = 1'b1;
          state_d = R;
        end
      end
      R: begin
        m.m_rready = 1'b1;
        beat       = m.m_rvalid;
        if (m.m_rvalid && ctr_tc) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle still carries the registered last word; pulse after it.
        if (!fill_we) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset)
      araddr_q <= '0;
    else if (state_q == IDLE && miss_valid)
      araddr_q <= miss_addr & ~OFF_MASK;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      fill_we   <= 1'b0;
      fill_idx  <= '0;
      fill_data <= '0;
    end else begin
      fill_we <= beat;
      if (beat) begin
        fill_idx  <= ctr;
        fill_data <= m.m_rdata;
      end
    end
  end

`ifdef REFILL_RLAST_CHECK_EN
  always_ff @(posedge aclk) begin
    if (areset)
      fill_err <= 1'b0;
    else if (beat && (m.m_rlast != ctr_tc))
      fill_err <= 1'b1;
  end
`else
  logic unused_rlast;
  assign unused_rlast = m.m_rlast;
  assign fill_err     = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill_axi.sv
// Scoreboard bench for icache_refill_axi: directed misses, queue-based fill/AR monitor.
module tb_icache_refill_axi;
  localparam int LW = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = '0;
  logic        fill_we;
  logic [3:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fill_done;
  logic        fill_err;

  icache_refill_axi_if #(.ADDR_W(32)) bus ();

  icache_refill_axi #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .miss_valid (miss_valid),
    .miss_ready (miss_ready),
    .miss_addr  (miss_addr),
    .m          (bus),
    .fill_we    (fill_we),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data),
    .fill_done  (fill_done),
    .fill_err   (fill_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          done;
    int          idx;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] arq[$];
  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0;

`ifdef REFILL_RLAST_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: AR handshakes and fill stream/completion against the queues.
  always @(negedge aclk) begin
    exp_t e;
    logic [31:0] a;
    if (bus.m_arvalid && bus.m_arready) begin
      if (arq.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        a = arq.pop_front();
        check("araddr", bus.m_araddr, a);
        check("ar_const", {bus.m_arid, bus.m_arlen, 1'b0, bus.m_arsize}, {4'd1, 4'hF, 1'b0, 3'd2});
      end
    end
    if (fill_we) begin
      if (expq.size() == 0) check("fill_we_unexpected", 1, 0);
      else begin
        e = expq.pop_front();
        check("fill_kind_we", e.done, 0);
        check("fill_idx", fill_idx, e.idx);
        check("fill_data", fill_data, e.data);
      end
    end
    if (fill_done) begin
      done_cyc = cyc;
      check("miss_ready_in_done", miss_ready, 0);
      check("done_not_with_we", fill_we, 0);
      if (expq.size() == 0) check("fill_done_unexpected", 1, 0);
      else begin
        e = expq.pop_front();
        check("fill_kind_done", e.done, 1);
        check("done_latency", cyc - acc_cyc + 1, e.lat);
      end
    end
  end

  task automatic wait_accept(input bit chk_b2b);
    int w = 0;
    @(negedge aclk);
    while (!miss_ready && w < 200) begin
      @(negedge aclk);
      w++;
    end
    check("accept_timeout", w < 200, 1);
    if (chk_b2b) check("b2b_ready_after_done", cyc, done_cyc + 1);
    @(posedge aclk);
    #1 acc_cyc = cyc;
  endtask

  task automatic run_miss(input logic [31:0] line, input int stall, input int gap, input int early,
                          input logic [31:0] base, input bit hold, input logic [31:0] next_addr,
                          input bit chk_b2b);
    int w;
    arq.push_back(line);
    for (int i = 0; i < LW; i++) expq.push_back('{1'b0, i, base + 32'(i), 0});
    expq.push_back('{1'b1, 0, 32'h0, LW + 3 + stall + gap * (LW - 1)});
    wait_accept(chk_b2b);
    miss_valid = hold;
    if (hold) miss_addr = next_addr;
    bus.m_arready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge aclk);
      check("ar_stall_valid", bus.m_arvalid, 1);
      check("ar_stall_addr", bus.m_araddr, line);
      check("ar_stall_mready", miss_ready, 0);
      @(posedge aclk);
      #1;
    end
    bus.m_arready = 1'b1;
    @(negedge aclk);
    check("ar_valid", bus.m_arvalid, 1);
    @(posedge aclk);
    #1 bus.m_arready = 1'b0;
    for (int i = 0; i < LW; i++) begin
      if (i > 0) for (int g = 0; g < gap; g++) begin
        bus.m_rvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = base + 32'(i);
      bus.m_rlast  = (i == LW - 1) || (i == early);
      @(negedge aclk);
      check("r_ready_mready", {bus.m_rready, miss_ready}, 2'b10);
      @(posedge aclk);
      #1;
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    w = 0;
    while (expq.size() != 0 && w < 40) begin
      @(posedge aclk);
      w++;
    end
    check("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rlast   = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_outputs", {bus.m_arvalid, bus.m_rready, fill_we, fill_done, fill_err}, 0);
    check("rst_araddr", bus.m_araddr, 0);
    check("rst_miss_ready", miss_ready, 1);

    // Basic refill
    @(posedge aclk);
    #1 miss_valid = 1'b1; miss_addr = 32'h1FC0_0024;
    run_miss(32'h1FC0_0000, 0, 0, -1, 32'hA000_0000, 1'b0, 32'h0, 1'b0);

    // AR backpressure
    #1 miss_valid = 1'b1; miss_addr = 32'h1234_5678;
    run_miss(32'h1234_5640, 5, 0, -1, 32'hB000_0000, 1'b0, 32'h0, 1'b0);

    // R gaps 1,0,0,1,...
    #1 miss_valid = 1'b1; miss_addr = 32'h8000_00FF;
    run_miss(32'h8000_00C0, 0, 2, -1, 32'hC000_0000, 1'b0, 32'h0, 1'b0);

    // Back-to-back misses with miss_valid held
    #1 miss_valid = 1'b1; miss_addr = 32'h2000_0010;
    run_miss(32'h2000_0000, 0, 0, -1, 32'hE000_0000, 1'b1, 32'h0000_0040, 1'b0);
    run_miss(32'h0000_0040, 0, 0, -1, 32'hF000_0000, 1'b0, 32'h0, 1'b1);
    check("err_clean", fill_err, 0);

    // Reset after beat 7
    #1 miss_valid = 1'b1; miss_addr = 32'h3000_0004;
    arq.push_back(32'h3000_0000);
    for (int i = 0; i < 8; i++) expq.push_back('{1'b0, i, 32'h5500_0000 + 32'(i), 0});
    wait_accept(1'b0);
    miss_valid = 1'b0;
    bus.m_arready = 1'b1;
    @(posedge aclk);
    #1 bus.m_arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = 32'h5500_0000 + 32'(i);
      @(posedge aclk);
      #1;
    end
    bus.m_rvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("midrst_outputs", {bus.m_arvalid, bus.m_rready, fill_we, fill_done, fill_err}, 0);
    check("midrst_regs", {bus.m_araddr, 4'h0, fill_idx}, 0);
    check("midrst_fill_data", fill_data, 0);
    check("midrst_miss_ready", miss_ready, 1);
    repeat (4) @(posedge aclk);
    check("midrst_queue", expq.size(), 0);

    // Early RLAST on beat 14
    #1 miss_valid = 1'b1; miss_addr = 32'h0000_1000;
    run_miss(32'h0000_1000, 0, 0, 14, 32'hD000_0000, 1'b0, 32'h0, 1'b0);
    check("err_early_rlast", fill_err, ERR_EN);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("err_sticky", fill_err, ERR_EN);
    #1 areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("err_cleared", fill_err, 0);
    check("arq_empty", arq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
